// File: rtl/fp_div_pkg.sv
// ============================================================================
// Module   : fp_div_pkg
// Brief    : Shared types and constants for the divider result stage.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package fp_div_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    typedef struct packed {
        logic ovf;
        logic unf;
    } fpdiv_flags_t;

    localparam logic [7:0]  FP_EXP_INF   = 8'hFF;
    localparam logic [22:0] FP_FRAC_ZERO = 23'd0;
    localparam int          FIFO_W       = 34;

    typedef enum logic [1:0] {
        OCC_EMPTY   = 2'd0,
        OCC_PARTIAL = 2'd1,
        OCC_FULL    = 2'd2
    } fifo_occ_t;

    // Overflow dominates underflow; the sign always survives saturation.
    function automatic fp32_t fp_fixup(input fp32_t r, input fpdiv_flags_t f);
        fp32_t o;
        o = r;
        if (f.ovf) begin
            o.exp  = FP_EXP_INF;
            o.frac = FP_FRAC_ZERO;
        end else if (f.unf) begin
            o.exp  = 8'd0;
            o.frac = FP_FRAC_ZERO;
        end
        return o;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_div_out_fifo.sv
// ============================================================================
// Module   : fp_div_out_fifo
// Brief    : Generic synchronous FIFO with valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fp_div_out_fifo
    import fp_div_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = FIFO_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             pop_valid_o,
    input  logic             pop_ready_i,
    output logic [WIDTH-1:0] pop_data_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    fifo_occ_t        w_occ;
    logic             w_push;
    logic             w_pop;

    // Extra pointer MSB separates full from empty when the indices match.
    always_comb begin
        w_occ = OCC_PARTIAL;
        if (wr_ptr_q == rd_ptr_q) begin
            w_occ = OCC_EMPTY;
        end else if ((wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0])) begin
            w_occ = OCC_FULL;
        end
    end

    assign pop_valid_o  = (w_occ != OCC_EMPTY);
    assign w_pop        = pop_valid_o & pop_ready_i;
    assign push_ready_o = (w_occ != OCC_FULL) | w_pop;
    assign w_push       = push_valid_i & push_ready_o;
    assign pop_data_o   = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, w_push};
    assign rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, w_pop};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (w_push) begin
                mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_div_result_stage.sv
// ============================================================================
// Module   : fp_div_result_stage
// Brief    : Registered result stage after the FP32 divider: saturation
//            fix-up, output FIFO, sticky exception flags. Optional exception
//            counters are built when FPDIV_STAT_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fp_div_result_stage
    import fp_div_pkg::*;
#(
    parameter int DEPTH = 2
`ifdef FPDIV_STAT_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      div_result,
    input  logic             div_overflow,
    input  logic             div_underflow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [1:0]       out_flags,
    output logic             sticky_ovf,
    output logic             sticky_unf,
    input  logic             flag_clr
`ifdef FPDIV_STAT_CNT_EN
    ,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic [CNT_W-1:0] unf_cnt
`endif
);

    fp32_t            w_res_in;
    fp32_t            w_res_fix;
    fpdiv_flags_t     w_flags_in;
    logic [FIFO_W-1:0] w_head;
    logic             w_accept;
    logic             w_acc_ovf;
    logic             w_acc_unf;
    logic             sticky_ovf_q, sticky_ovf_d;
    logic             sticky_unf_q, sticky_unf_d;

    assign w_res_in   = div_result;
    assign w_flags_in = {div_overflow, div_underflow};
    assign w_res_fix  = fp_fixup(w_res_in, w_flags_in);

    fp_div_out_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_valid_i (in_valid),
        .push_ready_o (in_ready),
        .push_data_i  ({w_res_fix, w_flags_in}),
        .pop_valid_o  (out_valid),
        .pop_ready_i  (out_ready),
        .pop_data_o   (w_head)
    );

    assign out_data  = w_head[FIFO_W-1:2];
    assign out_flags = w_head[1:0];

    assign w_accept  = in_valid & in_ready;
    assign w_acc_ovf = w_accept & w_flags_in.ovf;
    assign w_acc_unf = w_accept & w_flags_in.unf;

    // A new exception in the clearing cycle must not be lost, so set wins.
    always_comb begin
        sticky_ovf_d = sticky_ovf_q;
        sticky_unf_d = sticky_unf_q;
        if (flag_clr) begin
            sticky_ovf_d = 1'b0;
            sticky_unf_d = 1'b0;
        end
        if (w_acc_ovf) sticky_ovf_d = 1'b1;
        if (w_acc_unf) sticky_unf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_ovf_q <= 1'b0;
            sticky_unf_q <= 1'b0;
        end else begin
            sticky_ovf_q <= sticky_ovf_d;
            sticky_unf_q <= sticky_unf_d;
        end
    end

    assign sticky_ovf = sticky_ovf_q;
    assign sticky_unf = sticky_unf_q;

`ifdef FPDIV_STAT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
    logic [CNT_W-1:0] unf_cnt_q, unf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        unf_cnt_d = unf_cnt_q;
        if (flag_clr) begin
            ovf_cnt_d = w_acc_ovf ? CNT_ONE : '0;
            unf_cnt_d = w_acc_unf ? CNT_ONE : '0;
        end else begin
            if (w_acc_ovf && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + CNT_ONE;
            if (w_acc_unf && (unf_cnt_q != '1)) unf_cnt_d = unf_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt_q <= '0;
            unf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
            unf_cnt_q <= unf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
    assign unf_cnt = unf_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fp_div_result_stage.sv
// ============================================================================
// Module   : tb_fp_div_result_stage
// Brief    : Self-checking bench for fp_div_result_stage (queue-based model).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fp_div_result_stage;

    localparam int DEPTH = 2;
    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] div_result = '0;
    logic        div_overflow = 1'b0;
    logic        div_underflow = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [1:0]  out_flags;
    logic        sticky_ovf;
    logic        sticky_unf;
    logic        flag_clr = 1'b0;
`ifdef FPDIV_STAT_CNT_EN
    logic [CNT_W-1:0] ovf_cnt;
    logic [CNT_W-1:0] unf_cnt;
`endif

    always #5 clk = ~clk;

    fp_div_result_stage #(
        .DEPTH (DEPTH)
`ifdef FPDIV_STAT_CNT_EN
        , .CNT_W (CNT_W)
`endif
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .div_result    (div_result),
        .div_overflow  (div_overflow),
        .div_underflow (div_underflow),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_flags     (out_flags),
        .sticky_ovf    (sticky_ovf),
        .sticky_unf    (sticky_unf),
        .flag_clr      (flag_clr)
`ifdef FPDIV_STAT_CNT_EN
        , .ovf_cnt     (ovf_cnt)
        , .unf_cnt     (unf_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: entries are {result, ovf, unf}
    logic [33:0] mq[$];
    bit          m_sovf = 0;
    bit          m_sunf = 0;
    int          m_covf = 0;
    int          m_cunf = 0;
    bit          m_acc;
    bit          m_pop;

    function automatic logic [33:0] ref_fix(input logic [31:0] d, input bit o, input bit u);
        logic [31:0] r;
        if (o)      r = {d[31], 8'hFF, 23'd0};
        else if (u) r = {d[31], 31'd0};
        else        r = d;
        return {r, o, u};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_sovf = 0;
            m_sunf = 0;
            m_covf = 0;
            m_cunf = 0;
        end else begin
            m_pop = (mq.size() > 0) && out_ready;
            m_acc = in_valid && ((mq.size() < DEPTH) || m_pop);
            if (m_pop) void'(mq.pop_front());
            if (m_acc) mq.push_back(ref_fix(div_result, div_overflow, div_underflow));
            if (m_acc && div_overflow) m_sovf = 1; else if (flag_clr) m_sovf = 0;
            if (m_acc && div_underflow) m_sunf = 1; else if (flag_clr) m_sunf = 0;
            if (flag_clr) begin
                m_covf = (m_acc && div_overflow) ? 1 : 0;
                m_cunf = (m_acc && div_underflow) ? 1 : 0;
            end else begin
                if (m_acc && div_overflow && m_covf < CMAX) m_covf++;
                if (m_acc && div_underflow && m_cunf < CMAX) m_cunf++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready", {31'd0, in_ready},
                {31'd0, (mq.size() < DEPTH) || ((mq.size() > 0) && out_ready)});
            chk("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
            if (mq.size() > 0) begin
                chk("out_data", out_data, mq[0][33:2]);
                chk("out_flags", {30'd0, out_flags}, {30'd0, mq[0][1:0]});
            end
            chk("sticky_ovf", {31'd0, sticky_ovf}, {31'd0, m_sovf});
            chk("sticky_unf", {31'd0, sticky_unf}, {31'd0, m_sunf});
`ifdef FPDIV_STAT_CNT_EN
            chk("ovf_cnt", {16'd0, ovf_cnt}, m_covf);
            chk("unf_cnt", {16'd0, unf_cnt}, m_cunf);
`endif
        end
    end

    // Inputs are set at posedge+1 and held across the next active edge.
    task automatic drive(input bit v, input logic [31:0] d, input bit o, input bit u,
                         input bit r, input bit c);
        in_valid      = v;
        div_result    = d;
        div_overflow  = o;
        div_underflow = u;
        out_ready     = r;
        flag_clr      = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_sticky", {30'd0, sticky_ovf, sticky_unf}, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        drive(1, 32'h3FC00000, 0, 0, 1, 0);
        chk("pass_data", out_data, 32'h3FC00000);
        chk("pass_flags", {30'd0, out_flags}, 32'd0);
        chk("pass_sticky", {30'd0, sticky_ovf, sticky_unf}, 32'd0);

        drive(1, 32'hC1234567, 1, 0, 1, 0);
        chk("ovf_data", out_data, 32'hFF800000);
        chk("ovf_flags", {30'd0, out_flags}, 32'd2);
        chk("ovf_sticky", {31'd0, sticky_ovf}, 32'd1);
        drive(1, 32'h00001234, 0, 1, 1, 0);
        chk("unf_data", out_data, 32'h00000000);
        chk("unf_sticky", {31'd0, sticky_unf}, 32'd1);
        drive(1, 32'h80ABCDEF, 1, 1, 1, 0);
        chk("both_data", out_data, 32'hFF800000);
        chk("both_flags", {30'd0, out_flags}, 32'd3);
        drive(0, 32'd0, 0, 0, 1, 1);
        chk("clr_sticky", {30'd0, sticky_ovf, sticky_unf}, 32'd0);

        drive(1, 32'h11111111, 0, 0, 0, 0);
        drive(1, 32'h22222222, 0, 0, 0, 0);
        chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp_head", out_data, 32'h11111111);
        drive(1, 32'h33333333, 0, 0, 0, 0);
        chk("bp_hold", out_data, 32'h11111111);
        chk("bp_still_full", {31'd0, in_ready}, 32'd0);

        in_valid   = 1'b1;
        div_result = 32'h44444444;
        out_ready  = 1'b1;
        #1;
        chk("full_pushpop_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        chk("full_pushpop_order", out_data, 32'h22222222);
        drive(0, 32'd0, 0, 0, 1, 0);
        chk("drain_last", out_data, 32'h44444444);
        drive(0, 32'd0, 0, 0, 1, 0);
        chk("drain_empty", {31'd0, out_valid}, 32'd0);

        drive(1, 32'h40000000, 1, 0, 1, 1);
        chk("race_set_wins", {31'd0, sticky_ovf}, 32'd1);
        drive(0, 32'd0, 0, 0, 1, 1);
        chk("race_clear", {31'd0, sticky_ovf}, 32'd0);

        drive(1, 32'h55555555, 1, 1, 0, 0);
        drive(1, 32'h66666666, 0, 0, 0, 0);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_sticky", {30'd0, sticky_ovf, sticky_unf}, 32'd0);
`ifdef FPDIV_STAT_CNT_EN
        chk("arst_cnt", {ovf_cnt, unf_cnt}, 32'd0);
`endif
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        repeat (3000) begin
            drive(($urandom_range(0, 9) < 7), $urandom,
                  ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 15),
                  ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 5));
        end

`ifdef FPDIV_STAT_CNT_EN
        drive(0, 32'd0, 0, 0, 1, 1);
        repeat (CMAX + 4) drive(1, $urandom, 1, 0, 1, 0);
        drive(0, 32'd0, 0, 0, 1, 0);
        chk("ovf_cnt_sat", {16'd0, ovf_cnt}, 32'h0000FFFF);
`endif
        drive(0, 32'd0, 0, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
